// File: rtl/collector_stream_if.sv
// collector_stream_if
//   Bundles the packet-side and operand-side handshakes of collector_stream.
//   Parameters DATA_WID / DATAIN must match the collector they connect to.
//
//   Signals:
//     datain    packet {idx, last, payload}        (host -> collector)
//     din_valid packet present                     (host -> collector)
//     din_ready collector can take a packet        (collector -> host)
//     a         assembled operand                  (collector -> consumer)
//     a_valid   operand complete, held until taken (collector -> consumer)
//     a_ready   consumer takes the operand         (consumer -> collector)
//     seq_err   one-cycle sequence violation pulse (collector -> host)
//
//   Modports:
//     master  host/consumer view (drives datain, din_valid, a_ready)
//     slave   collector view
interface collector_stream_if #(
  parameter int DATA_WID = 256,
  parameter int DATAIN   = 48
);
  logic [DATAIN-1:0]   datain;
  logic                din_valid;
  logic                din_ready;
  logic [DATA_WID-1:0] a;
  logic                a_valid;
  logic                a_ready;
  logic                seq_err;

  modport master (
    output datain, din_valid, a_ready,
    input  din_ready, a, a_valid, seq_err
  );

  modport slave (
    input  datain, din_valid, a_ready,
    output din_ready, a, a_valid, seq_err
  );
endinterface

// File: rtl/collector_stream.sv
// collector_stream
//   Assembles a DATA_WID-bit operand from a stream of DATAIN-bit packets,
//   each tagged with a slot index and a last flag, and presents the operand
//   with a valid/ready handshake to the square-root core.
//
//   Packet layout: [DATAIN-1 -: HDR_WID] = idx, [PAYLOAD] = last,
//                  [PAYLOAD-1:0] = payload.  idx 0 is an idle filler.
//   Slot k (1..NUM_PKTS-1) lands at a[DATA_WID-1-(k-1)*PAYLOAD -: PAYLOAD];
//   slot NUM_PKTS lands at a[LAST_BITS-1:0] from the top payload bits.
//
//   Ports:
//     clk   clock, all logic on the rising edge
//     rst   synchronous reset, active-high
//     bus   collector_stream_if.slave (datain, din_valid, din_ready,
//           a, a_valid, a_ready, seq_err)
//
//   Build option:
//     COLLECTOR_SEQ_CHECK_EN  when defined, packets must arrive in slot
//       order (idx 1 may restart at any time); violations are dropped and
//       flagged on seq_err.  When undefined, slots are accepted in any
//       order, out-of-range indices are ignored and seq_err is tied low.
module collector_stream #(
  parameter int DATA_WID = 256,
  parameter int DATAIN   = 48,
  parameter int HDR_WID  = 3
) (
  input logic               clk,
  input logic               rst,
  collector_stream_if.slave bus
);

  localparam int PAYLOAD   = DATAIN - HDR_WID - 1;
  localparam int NUM_PKTS  = (DATA_WID + PAYLOAD - 1) / PAYLOAD;
  localparam int LAST_BITS = DATA_WID - (NUM_PKTS - 1) * PAYLOAD;

  localparam logic [HDR_WID-1:0] FIRST_IDX = HDR_WID'(1);
  localparam logic [HDR_WID-1:0] LAST_IDX  = HDR_WID'(NUM_PKTS);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [DATA_WID-1:0] a_q;
  logic [DATA_WID-1:0] a_next;

  logic [HDR_WID-1:0]  idx;
  logic                last;
  logic [PAYLOAD-1:0]  payload;

  logic                accept;
  logic                in_range;
  logic                is_final;
  logic                write_ok;

  assign idx     = bus.datain[DATAIN-1 -: HDR_WID];
  assign last    = bus.datain[PAYLOAD];
  assign payload = bus.datain[PAYLOAD-1:0];

  // Ready drops during reset so nothing is handed over on a reset edge.
  assign bus.din_ready = !rst && (state != HOLD);
  assign bus.a_valid   = (state == HOLD);
  assign bus.a         = a_q;

  assign accept   = bus.din_valid && bus.din_ready && (idx != '0);
  assign in_range = (idx <= LAST_IDX);
  assign is_final = (idx == LAST_IDX) && last;

`ifdef COLLECTOR_SEQ_CHECK_EN
  logic [HDR_WID-1:0] expect_idx;
  logic [HDR_WID-1:0] expect_next;
  logic               err_q;
  logic               err_next;
  logic               bad;

  // idx 1 is always legal so a restarted operand resynchronises cleanly.
  assign bad = !in_range
             || ((idx != expect_idx) && (idx != FIRST_IDX))
             || (last && (idx < LAST_IDX))
             || ((idx == LAST_IDX) && !last);

  assign write_ok    = accept && !bad;
  assign bus.seq_err = err_q;
`else
  assign write_ok    = accept && in_range;
  assign bus.seq_err = 1'b0;
`endif

  // Each slot's bits either take the incoming payload when their index is
  // accepted or keep their previous value; together the slots cover every
  // bit of the operand exactly once.
  for (genvar k = 1; k < NUM_PKTS; k++) begin : g_slot
    localparam int                 HI       = DATA_WID - 1 - (k - 1) * PAYLOAD;
    localparam logic [HDR_WID-1:0] SLOT_IDX = HDR_WID'(k);
    assign a_next[HI -: PAYLOAD] = (write_ok && (idx == SLOT_IDX))
                                   ? payload : a_q[HI -: PAYLOAD];
  end

  // The final slot is narrower than a payload; it keeps the top payload
  // bits and discards the rest.
  assign a_next[LAST_BITS-1:0] = (write_ok && (idx == LAST_IDX))
                                 ? payload[PAYLOAD-1 -: LAST_BITS]
                                 : a_q[LAST_BITS-1:0];

  // Next-state logic: collect until the final slot arrives with last set,
  // then hold the operand until the consumer takes it.
  always_comb begin
    state_next = state;
`ifdef COLLECTOR_SEQ_CHECK_EN
    expect_next = expect_idx;
    err_next    = 1'b0;
`endif
    case (state)
      IDLE, COLLECT: begin
        if (write_ok) begin
          state_next = is_final ? HOLD : COLLECT;
`ifdef COLLECTOR_SEQ_CHECK_EN
          expect_next = is_final ? FIRST_IDX : idx + FIRST_IDX;
        end else if (accept) begin
          state_next  = IDLE;
          expect_next = FIRST_IDX;
          err_next    = 1'b1;
`endif
        end
      end
      HOLD: begin
        if (bus.a_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and operand registers; reset discards any partial operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
    end else begin
      state <= state_next;
      a_q   <= a_next;
    end
  end

`ifdef COLLECTOR_SEQ_CHECK_EN
  // Expected-index tracker and the registered error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      expect_idx <= FIRST_IDX;
      err_q      <= 1'b0;
    end else begin
      expect_idx <= expect_next;
      err_q      <= err_next;
    end
  end
`endif

endmodule

// File: tb/tb_collector_stream.sv
// tb_collector_stream
//   Randomised and directed stimulus for collector_stream at default
//   parameters, plus a directed run of a 128-bit / 40-bit instance.
//   Completed operands and expected seq_err pulses are queued by a
//   slot-level reference model and consumed by an independent monitor.
module tb_collector_stream;

  localparam int PL = 44;
  localparam int NP = 6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  collector_stream_if #(.DATA_WID(256), .DATAIN(48)) bus ();
  collector_stream #(.DATA_WID(256), .DATAIN(48), .HDR_WID(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  collector_stream_if #(.DATA_WID(128), .DATAIN(40)) bus2 ();
  collector_stream #(.DATA_WID(128), .DATAIN(40), .HDR_WID(3)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int           checkCount = 0;
  int           failCount  = 0;
  logic [255:0] aQ[$];
  int           errQ[$];

  logic [PL-1:0] mSlot [1:NP];
  int            mExpect;
  bit            autoReady = 1'b0;

  logic          monPrev = 1'b0;
  logic [255:0]  monHeld;

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Operand = slots 1..NP-1 concatenated, then the top 36 bits of slot NP.
  function automatic logic [255:0] modelOperand();
    logic [255:0] r;
    r = '0;
    for (int k = 1; k < NP; k++) r = (r << PL) | 256'(mSlot[k]);
    r = (r << 36) | 256'(mSlot[NP] >> 8);
    return r;
  endfunction

  task automatic modelReset();
    for (int k = 1; k <= NP; k++) mSlot[k] = '0;
    mExpect = 1;
  endtask

  task automatic modelAccept(input int idx, input bit last, input logic [PL-1:0] pl);
    if (idx == 0) return;
`ifdef COLLECTOR_SEQ_CHECK_EN
    if (idx > NP || (idx != mExpect && idx != 1) || (last && idx < NP) || (idx == NP && !last)) begin
      errQ.push_back(1);
      mExpect = 1;
      return;
    end
    mSlot[idx] = pl;
    if (idx == NP) begin
      aQ.push_back(modelOperand());
      mExpect = 1;
    end else begin
      mExpect = idx + 1;
    end
`else
    if (idx > NP) return;
    mSlot[idx] = pl;
    mExpect = (idx == NP) ? 1 : idx + 1;
    if (idx == NP && last) aQ.push_back(modelOperand());
`endif
  endtask

  // Present one packet and wait (bounded) until it is taken.
  task automatic applyStimulus(input int idx, input bit last, input logic [PL-1:0] pl);
    int budget;
    budget = 0;
    bus.datain    = {3'(idx), last, pl};
    bus.din_valid = 1'b1;
    while (bus.din_ready !== 1'b1 && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (bus.din_ready !== 1'b1) begin
      checkOutput("din_ready timeout", bus.din_ready, 1);
    end else begin
      @(posedge clk); #1;
      modelAccept(idx, last, pl);
    end
    bus.din_valid = 1'b0;
  endtask

  task automatic releaseOp();
    bus.a_ready = 1'b1;
    @(posedge clk); #1;
    bus.a_ready = 1'b0;
    checkOutput("a_valid after release", bus.a_valid, 0);
    checkOutput("din_ready after release", bus.din_ready, 1);
  endtask

  task automatic applySmall(input int idx, input bit last, input logic [35:0] pl);
    bus2.datain    = {3'(idx), last, pl};
    bus2.din_valid = 1'b1;
    checkOutput("small din_ready", bus2.din_ready, 1);
    @(posedge clk); #1;
    bus2.din_valid = 1'b0;
  endtask

  // Consumer handshake during the random phase.
  initial begin
    forever begin
      @(negedge clk);
      if (autoReady) bus.a_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops expected operands and error pulses as the DUT shows them.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.a_valid === 1'b1 && !monPrev) begin
        if (aQ.size() == 0) checkOutput("a_valid without operand", bus.a_valid, 0);
        else checkOutput("operand", bus.a, aQ.pop_front());
        monHeld = bus.a;
      end else if (bus.a_valid === 1'b1) begin
        checkOutput("held operand", bus.a, monHeld);
      end
      if (bus.seq_err !== 1'b0) begin
        if (errQ.size() == 0) begin
          checkOutput("unexpected seq_err", bus.seq_err, 0);
        end else begin
          void'(errQ.pop_front());
          checkOutput("seq_err pulse", bus.seq_err, 1);
        end
      end
      monPrev = (bus.a_valid === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] rnd;
    logic [35:0] p1, p2, p3, p4a, p4b;
    int          idx;
    bit          last;

    bus.datain     = '0;
    bus.din_valid  = 1'b0;
    bus.a_ready    = 1'b0;
    bus2.datain    = '0;
    bus2.din_valid = 1'b0;
    bus2.a_ready   = 1'b0;
    rst            = 1'b1;
    modelReset();

    // Reset state
    @(posedge clk); #1;
    checkOutput("din_ready in reset", bus.din_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("reset a", bus.a, 0);
    checkOutput("reset a_valid", bus.a_valid, 0);
    checkOutput("reset seq_err", bus.seq_err, 0);
    checkOutput("idle din_ready", bus.din_ready, 1);

    // Ordered fill
    for (int k = 1; k <= NP; k++) applyStimulus(k, k == NP, {11{4'(k)}});
    checkOutput("a_valid after final", bus.a_valid, 1);
    checkOutput("slot1 field", bus.a[255:212], 44'h11111111111);
    checkOutput("slot6 field", bus.a[35:0], 36'h666666666);
    checkOutput("din_ready while held", bus.din_ready, 0);

    // Hold: a packet offered while held is not taken
    bus.datain    = {3'd1, 1'b0, 44'hABCDEF01234};
    bus.din_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput("hold a frozen", bus.a, modelOperand());
      checkOutput("hold din_ready", bus.din_ready, 0);
      checkOutput("hold a_valid", bus.a_valid, 1);
    end
    bus.din_valid = 1'b0;
    releaseOp();

`ifdef COLLECTOR_SEQ_CHECK_EN
    // Sequence error, then a stray idx 2 from IDLE, then a clean operand
    applyStimulus(1, 0, 44'h0A0A0A0A0A0);
    applyStimulus(2, 0, 44'h0B0B0B0B0B0);
    applyStimulus(4, 0, 44'h0D0D0D0D0D0);
    checkOutput("seq_err on idx 4", bus.seq_err, 1);
    applyStimulus(2, 0, 44'h0E0E0E0E0E0);
    checkOutput("seq_err idx 2 from idle", bus.seq_err, 1);
    for (int k = 1; k <= NP; k++) applyStimulus(k, k == NP, {11{4'(k + 8)}});
    checkOutput("a_valid after recovery", bus.a_valid, 1);
    releaseOp();

    // Resync: restart with idx 1 in the middle of an operand
    for (int k = 1; k <= 3; k++) applyStimulus(k, 0, {11{4'hF}});
    for (int k = 1; k <= NP; k++) applyStimulus(k, k == NP, {11{4'(k + 2)}});
    checkOutput("a_valid after resync", bus.a_valid, 1);
    checkOutput("resync slot1", bus.a[255:212], 44'h33333333333);
    releaseOp();
`else
    // Legacy order: out-of-order, repeats, idx 6 without last, idx 7 ignored
    applyStimulus(3, 1, 44'h33333333333);
    applyStimulus(6, 0, 44'h66666666666);
    checkOutput("no completion without last", bus.a_valid, 0);
    applyStimulus(7, 1, 44'h77777777777);
    applyStimulus(2, 0, 44'h22222222222);
    applyStimulus(2, 0, 44'h2A2A2A2A2A2);
    applyStimulus(1, 0, 44'h11111111111);
    applyStimulus(4, 0, 44'h44444444444);
    applyStimulus(5, 0, 44'h55555555555);
    applyStimulus(6, 1, 44'h6789ABCDEF0);
    checkOutput("legacy completion", bus.a_valid, 1);
    checkOutput("legacy last slot", bus.a[35:0], 36'h6789ABCDE);
    releaseOp();
`endif

    // Reset mid-collection
    for (int k = 1; k <= 3; k++) applyStimulus(k, 0, {11{4'(k + 4)}});
    rst = 1'b1;
    #1;
    checkOutput("din_ready during rst", bus.din_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("a after mid reset", bus.a, 0);
    checkOutput("a_valid after mid reset", bus.a_valid, 0);
`ifdef COLLECTOR_SEQ_CHECK_EN
    applyStimulus(2, 0, 44'h12121212121);
    checkOutput("expect restarted at 1", bus.seq_err, 1);
`endif
    for (int k = 1; k <= NP; k++) applyStimulus(k, k == NP, {11{4'(k + 6)}});
    checkOutput("a_valid after reset run", bus.a_valid, 1);
    releaseOp();

    // Random traffic checked by the monitor
    autoReady = 1'b1;
    for (int n = 0; n < 400; n++) begin
      idx = $urandom_range(0, 99);
      if (idx < 70)      idx = mExpect;
      else if (idx < 80) idx = 1;
      else               idx = $urandom_range(0, 7);
      last = (idx == NP);
      if ($urandom_range(0, 9) == 0) last = !last;
      rnd = {$urandom(), $urandom()};
      applyStimulus(idx, last, rnd[PL-1:0]);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin
        @(posedge clk); #1;
      end
    end
    repeat (20) begin
      @(posedge clk); #1;
    end
    autoReady = 1'b0;
    @(posedge clk); #1;
    bus.a_ready = 1'b0;

`ifndef COLLECTOR_SEQ_CHECK_EN
    // 128-bit instance: PAYLOAD 36, 4 slots, final slot 20 bits
    p1  = 36'h123456789;
    p2  = 36'h2468ACE02;
    p3  = 36'h3579BDF13;
    p4a = 36'h400000004;
    p4b = 36'hFEDCBA987;
    applySmall(4, 0, p4a);
    checkOutput("small no early completion", bus2.a_valid, 0);
    applySmall(3, 0, p3);
    applySmall(2, 0, p2);
    applySmall(1, 0, p1);
    checkOutput("small still collecting", bus2.a_valid, 0);
    applySmall(4, 1, p4b);
    checkOutput("small a_valid", bus2.a_valid, 1);
    checkOutput("small slot4", bus2.a[19:0], p4b[35:16]);
    checkOutput("small slot1", bus2.a[127:92], p1);
    checkOutput("small slot2", bus2.a[91:56], p2);
    checkOutput("small slot3", bus2.a[55:20], p3);
    bus2.a_ready = 1'b1;
    @(posedge clk); #1;
    bus2.a_ready = 1'b0;
    checkOutput("small release", bus2.a_valid, 0);
`endif

    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("pending operands", 256'(aQ.size()), 0);
    checkOutput("pending seq_err", 256'(errQ.size()), 0);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule

// File: doc/collector_stream.md
Name: collector_stream

Overview:
- Parametrised successor to the fixed 6×44-bit operand collector.
- Assembles a DATA_WID-bit operand from a stream of DATAIN-bit header-tagged packets. Each packet carries a slot index, a last flag and a payload.
- Adds a valid/ready handshake on both sides, held output and optional sequence checking.
- Sits between the host-side packet interface and the square-root core operand input.

Parameters:
- DATA_WID, 256, width of the assembled operand a
- DATAIN, 48, width of an input packet
- HDR_WID, 3, width of the slot-index field; requires 2**HDR_WID > NUM_PKTS

Derived, localparam:
- PAYLOAD = DATAIN-HDR_WID-1
- NUM_PKTS = ceil(DATA_WID/PAYLOAD)
- LAST_BITS = DATA_WID-(NUM_PKTS-1)*PAYLOAD
- Defaults give 44, 6 and 36.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- datain  in  DATAIN  packet: [DATAIN-1 -: HDR_WID]=idx, [PAYLOAD]=last, [PAYLOAD-1:0]=payload
- din_valid  in  1  packet present
- din_ready  out  1  block can accept a packet
- a  out  DATA_WID  assembled operand
- a_valid  out  1  operand complete, held until taken
- a_ready  in  1  consumer takes operand
- seq_err  out  1  one-cycle pulse on a sequence violation

Behaviour:
- Reset:
  - Applies at the next edge with rst=1 and overrides everything.
  - a=0, a_valid=0, seq_err=0, state=IDLE, expect=1.
  - din_ready=0 while rst=1.
  - Reset mid-collection discards the partial word.
- Accept condition: din_valid && din_ready && idx!=0. idx=0 is an idle filler: ignored, no error.
- Slot write on accept, at the same edge:
  - idx=k, 1≤k<NUM_PKTS: a[DATA_WID-1-(k-1)*PAYLOAD -: PAYLOAD] <= payload.
  - idx=NUM_PKTS: a[LAST_BITS-1:0] <= payload[PAYLOAD-1 -: LAST_BITS]; low PAYLOAD-LAST_BITS payload bits are discarded.
  - Bits not written keep their old value.
- States:
  - IDLE: din_ready=1, expect=1. First accepted packet → COLLECT.
  - COLLECT: din_ready=1. Accepted idx=NUM_PKTS with last=1 → HOLD.
  - HOLD: din_ready=0, a_valid=1, a frozen. On a_valid&&a_ready → IDLE, a_valid=0 at that edge. No new packet can be accepted in the release cycle.
- Latency:
  - a_valid rises at the edge that accepts the final packet, i.e. 1 cycle after it is presented.
  - Back-to-back operands need one cycle of din_ready=1 after release.
- Checked sequence (see Optional Feature): expect tracks the next index and increments on each good packet. A violation is any of:
  - idx>NUM_PKTS
  - idx!=expect, except idx=1
  - last=1 with idx<NUM_PKTS
  - idx=NUM_PKTS with last=0
- On violation:
  - Packet is dropped: no slot write.
  - seq_err pulses for exactly 1 cycle.
  - State → IDLE, expect=1.
- Resync: idx=1 accepted in COLLECT is not an error. Slot 1 is written and expect=2, so a restarted operand recovers without loss.
- Simultaneous events:
  - Violation and a_ready cannot coincide, since din_ready=0 in HOLD.
  - rst dominates a_ready and din_valid.

Optional Feature:
- Macro: COLLECTOR_SEQ_CHECK_EN.
- Defined: checked-sequence behaviour above applies.
- Undefined:
  - Legacy-compatible behaviour: indices 1..NUM_PKTS are accepted in any order and any repetition.
  - Completion = accepted idx=NUM_PKTS with last=1.
  - idx=NUM_PKTS with last=0 writes its slot without completing.
  - last on other indices is ignored; idx>NUM_PKTS is ignored silently.
  - seq_err is tied 0 and the expect counter is not built.

Test Plan:
- Ordered fill at defaults:
  - Stimulus: idx 1..6 back-to-back, payload k = {11{4'hk}}, last=1 on idx 6; a_ready=0.
  - Response: a_valid=1 the cycle after idx 6.
  - Response: a[255:212]=44'h111..1, …, a[35:0]=36'h666666666 (payload[43:8]).
  - Response: din_ready=0 while held.
- Hold/release: keep a_ready=0 for 5 cycles, drive din_valid=1 with idx=1 → a unchanged, no accept; raise a_ready 1 cycle → a_valid=0 and din_ready=1 next cycle.
- Sequence error (macro on): send 1,2,4 → seq_err single pulse on idx 4, slot 3/4 not written, state IDLE; then 1..6 completes normally.
- Resync (macro on): send 1,2,3,1,2,3,4,5,6(last) → no seq_err, a_valid asserts, slots 1–3 hold the second-pass payloads.
- Reset mid-op: send 1,2,3, assert rst 1 cycle → a=0, a_valid=0, din_ready=0 during rst, expect=1 afterwards.
- Non-default params (DATA_WID=128, DATAIN=40, HDR_WID=3 → PAYLOAD=36, NUM_PKTS=4, LAST_BITS=20), macro off:
  - Stimulus: order 4(last=0),3,2,1,4(last=1).
  - Response: completion only on the second idx 4; a[19:0]=payload[35:16].
